// File: rtl/ps2_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_dev_pkg
// Description : Shared types and constants for the PS/2 device-side engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_dev_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_TX_HI1 = 4'd1,
    ST_TX_LO  = 4'd2,
    ST_TX_HI2 = 4'd3,
    ST_RX_LO  = 4'd4,
    ST_RX_HI1 = 4'd5,
    ST_RX_HI2 = 4'd6,
    ST_ACK_LO = 4'd7,
    ST_ACK_HI = 4'd8,
    ST_GAP    = 4'd9
  } state_t;

  localparam int TX_BITS = 11;
  localparam int RX_BITS = 10;

  // Phase lengths in microseconds; scaled by the clock frequency in MHz.
  localparam int Q_US    = 20;
  localparam int H_US    = 40;
  localparam int IDLE_US = 50;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_od_line.sv
`default_nettype none
// ============================================================================
// Module      : ps2_od_line
// Description : Open-drain pad driver plus 2-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_od_line (
  input  logic clk,
  input  logic rst,
  input  logic drive_low,
  inout  wire  line,
  output logic line_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  assign line = drive_low ? 1'b0 : 1'bz;

  always_comb begin
    meta_d = line;
    sync_d = meta_q;
  end

  // Idle bus level is high, so the synchronizer resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign line_s = sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_device.sv
`default_nettype none
// ============================================================================
// Module      : ps2_device
// Description : PS/2 device emulator; sources the bus clock for both directions.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_device #(
  parameter int CLK_FREQ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_ack,
  output logic       tx_err,
  output logic       rx_busy,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       rx_err,
  inout  wire        ps2_clk,
  inout  wire        ps2_dat
);
  import ps2_dev_pkg::*;

  localparam int Q_CYC    = CLK_FREQ * Q_US;
  localparam int H_CYC    = CLK_FREQ * H_US;
  localparam int IDLE_CYC = CLK_FREQ * IDLE_US;
  localparam int TW       = $clog2(H_CYC + 1);
  localparam int IW       = $clog2(IDLE_CYC + 1);

  localparam logic [TW-1:0] Q_LOAD   = TW'(Q_CYC - 1);
  localparam logic [TW-1:0] H_LOAD   = TW'(H_CYC - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC);
  localparam logic [3:0]    TX_LAST  = 4'(TX_BITS - 1);
  localparam logic [3:0]    RX_LAST  = 4'(RX_BITS - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [10:0]     shift_q, shift_d;
  logic [9:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            clk_low_q, clk_low_d;
  logic            dat_low_q, dat_low_d;
  logic            tx_ack_q, tx_ack_d;
  logic            tx_err_q, tx_err_d;
  logic            rx_ack_q, rx_ack_d;
  logic            rx_err_q, rx_err_d;

  logic            clk_s, dat_s;
  logic            tmr_done;
  logic [3:0]      bit_next;

  ps2_od_line u_clk_line (
    .clk       (clk),
    .rst       (rst),
    .drive_low (clk_low_q),
    .line      (ps2_clk),
    .line_s    (clk_s)
  );

  ps2_od_line u_dat_line (
    .clk       (clk),
    .rst       (rst),
    .drive_low (dat_low_q),
    .line      (ps2_dat),
    .line_s    (dat_s)
  );

  assign tmr_done = (timer_q == '0);
  assign bit_next = bitcnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = tmr_done ? timer_q : timer_q - TW'(1);
    idle_d    = '0;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rxsh_d    = rxsh_q;
    rx_data_d = rx_data_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;
    tx_ack_d  = 1'b0;
    tx_err_d  = 1'b0;
    rx_ack_d  = 1'b0;
    rx_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clk_s && dat_s) begin
          idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
        end
        // A host request-to-send always beats a pending transmit.
        if (clk_s && !dat_s) begin
          state_d   = ST_RX_LO;
          bitcnt_d  = 4'd0;
          timer_d   = H_LOAD;
          clk_low_d = 1'b1;
          idle_d    = '0;
        end else if (tx_en && (idle_q == IDLE_MAX)) begin
          shift_d   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
          bitcnt_d  = 4'd0;
          state_d   = ST_TX_HI1;
          timer_d   = Q_LOAD;
          dat_low_d = 1'b1;
          idle_d    = '0;
        end
      end

      ST_TX_HI1: begin
        if (tmr_done) begin
          if (!clk_s && (bitcnt_q < TX_LAST)) begin
            dat_low_d = 1'b0;
            tx_err_d  = 1'b1;
            state_d   = ST_GAP;
            timer_d   = H_LOAD;
          end else begin
            clk_low_d = 1'b1;
            state_d   = ST_TX_LO;
            timer_d   = H_LOAD;
          end
        end
      end

      ST_TX_LO: begin
        if (tmr_done) begin
          clk_low_d = 1'b0;
          state_d   = ST_TX_HI2;
          timer_d   = Q_LOAD;
        end
      end

      ST_TX_HI2: begin
        if (tmr_done) begin
          if (bitcnt_q < TX_LAST) begin
            bitcnt_d  = bit_next;
            dat_low_d = ~shift_q[bit_next];
            state_d   = ST_TX_HI1;
            timer_d   = Q_LOAD;
          end else begin
            dat_low_d = 1'b0;
            tx_ack_d  = 1'b1;
            state_d   = ST_GAP;
            timer_d   = H_LOAD;
          end
        end
      end

      ST_RX_LO: begin
        if (tmr_done) begin
          clk_low_d = 1'b0;
          state_d   = ST_RX_HI1;
          timer_d   = Q_LOAD;
        end
      end

      ST_RX_HI1: begin
        if (tmr_done) begin
          rxsh_d[bitcnt_q] = dat_s;
          state_d          = ST_RX_HI2;
          timer_d          = Q_LOAD;
        end
      end

      ST_RX_HI2: begin
        if (tmr_done) begin
          if (bitcnt_q < RX_LAST) begin
            bitcnt_d  = bit_next;
            clk_low_d = 1'b1;
            state_d   = ST_RX_LO;
            timer_d   = H_LOAD;
          end else if ((^rxsh_q[8:0]) && rxsh_q[9]) begin
            rx_data_d = rxsh_q[7:0];
            clk_low_d = 1'b1;
            dat_low_d = 1'b1;
            state_d   = ST_ACK_LO;
            timer_d   = H_LOAD;
          end else begin
            rx_err_d = 1'b1;
            state_d  = ST_GAP;
            timer_d  = H_LOAD;
          end
        end
      end

      ST_ACK_LO: begin
        if (tmr_done) begin
          clk_low_d = 1'b0;
          state_d   = ST_ACK_HI;
          timer_d   = Q_LOAD;
        end
      end

      ST_ACK_HI: begin
        if (tmr_done) begin
          dat_low_d = 1'b0;
          rx_ack_d  = 1'b1;
          state_d   = ST_GAP;
          timer_d   = H_LOAD;
        end
      end

      ST_GAP: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      idle_q    <= '0;
      bitcnt_q  <= 4'd0;
      shift_q   <= '0;
      rxsh_q    <= '0;
      rx_data_q <= 8'd0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      tx_ack_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      rx_ack_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idle_q    <= idle_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rxsh_q    <= rxsh_d;
      rx_data_q <= rx_data_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
      tx_ack_q  <= tx_ack_d;
      tx_err_q  <= tx_err_d;
      rx_ack_q  <= rx_ack_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign tx_busy = (state_q == ST_TX_HI1) || (state_q == ST_TX_LO) || (state_q == ST_TX_HI2);
  assign rx_busy = (state_q == ST_RX_LO)  || (state_q == ST_RX_HI1) || (state_q == ST_RX_HI2) ||
                   (state_q == ST_ACK_LO) || (state_q == ST_ACK_HI);
  assign tx_ack  = tx_ack_q;
  assign tx_err  = tx_err_q;
  assign rx_ack  = rx_ack_q;
  assign rx_err  = rx_err_q;
  assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_device
// Description : Directed self-checking bench with a PS/2 host-side line model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_device;

  // 1 MHz scaling: Q = 20, H = 40, idle = 50, bit period = 80 cycles.
  localparam int CLK_FREQ = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_ack, tx_err, rx_busy, rx_ack, rx_err;
  logic [7:0] rx_data;
  wire        ps2_clk, ps2_dat;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_device #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_ack  (tx_ack),
    .tx_err  (tx_err),
    .rx_busy (rx_busy),
    .rx_data (rx_data),
    .rx_ack  (rx_ack),
    .rx_err  (rx_err),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   falls    = 0;
  int   cnt [0:3];
  int   rx_ack_cyc = 0;
  logic prev_clk = 1'b1;
  logic fall_dat [0:511];
  int   fall_cyc [0:511];

  initial for (int k = 0; k < 4; k++) cnt[k] = 0;

  // Bus monitor: host-side falling-edge capture and pulse counters.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
      fall_dat[falls & 511] = ps2_dat;
      fall_cyc[falls & 511] = cyc;
      falls = falls + 1;
    end
    prev_clk = ps2_clk;
    if (tx_ack === 1'b1) cnt[0] = cnt[0] + 1;
    if (tx_err === 1'b1) cnt[1] = cnt[1] + 1;
    if (rx_ack === 1'b1) begin cnt[2] = cnt[2] + 1; rx_ack_cyc = cyc; end
    if (rx_err === 1'b1) cnt[3] = cnt[3] + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n = 0;
    while (falls < target && n < budget) begin step(); n++; end
    check({tag, " reached"}, 32'(falls >= target), 32'd1);
  endtask

  task automatic wait_cnt(input int sel, input int target, input int budget, input string tag);
    int n = 0;
    while (cnt[sel] < target && n < budget) begin step(); n++; end
    check({tag, " reached"}, 32'(cnt[sel] >= target), 32'd1);
  endtask

  function automatic logic [10:0] frame_at(input int b);
    logic [10:0] v;
    for (int i = 0; i < 11; i++) v[i] = fall_dat[(b + i) & 511];
    return v;
  endfunction

  // Host request-to-send: clock low 100 us, data low, then clock release.
  task automatic host_rts(output int base);
    host_clk_low = 1'b1;
    repeat (100) step();
    host_dat_low = 1'b1;
    repeat (5) step();
    base = falls;
    host_clk_low = 1'b0;
  endtask

  // Host shifts data0..7, parity, stop while the device holds the clock low.
  task automatic host_bits(input int base, input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      wait_falls(base + i + 1, 400, "rx clock");
      repeat (2) step();
      host_dat_low = ~bits[i];
    end
  endtask

  initial begin
    int base, base2, a0, e0, r0, x0, t_pull, t_rel, n;

    // ---------------- reset state
    repeat (3) step();
    check("reset tx_busy", tx_busy, 0);
    check("reset rx_busy", rx_busy, 0);
    check("reset pulses", {tx_ack, tx_err, rx_ack, rx_err}, 0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset lines", {ps2_clk, ps2_dat}, 2'b11);
    rst = 1'b0;
    repeat (60) step();

    // ---------------- 1: transmit 0xA5
    base = falls; a0 = cnt[0]; e0 = cnt[1];
    tx_data = 8'hA5; tx_en = 1'b1;
    wait_cnt(0, a0 + 1, 2000, "t1 tx_ack");
    tx_en = 1'b0;
    check("t1 fall count", falls - base, 11);
    check("t1 frame", frame_at(base), 11'h74A);
    check_range("t1 first bit period", fall_cyc[(base + 1) & 511] - fall_cyc[base & 511], 79, 81);
    check_range("t1 last bit period", fall_cyc[(base + 10) & 511] - fall_cyc[(base + 9) & 511], 79, 81);
    repeat (5) step();
    check("t1 tx_ack pulses", cnt[0] - a0, 1);
    check("t1 tx_err pulses", cnt[1] - e0, 0);
    check("t1 busy after", tx_busy, 0);
    repeat (150) step();

    // ---------------- 2: receive 0xFF with good parity
    r0 = cnt[2]; x0 = cnt[3];
    host_rts(base);
    host_bits(base, {1'b1, 1'b1, 8'hFF});
    wait_falls(base + 11, 400, "t2 ack clock");
    repeat (5) step();
    check("t2 ack lines", {ps2_clk, ps2_dat}, 2'b00);
    check("t2 rx_busy", rx_busy, 1);
    wait_cnt(2, r0 + 1, 400, "t2 rx_ack");
    check("t2 rx_data", rx_data, 8'hFF);
    check("t2 fall count", falls - base, 11);
    check("t2 rx_err pulses", cnt[3] - x0, 0);
    repeat (150) step();

    // ---------------- 3: receive 0x00 with bad parity
    r0 = cnt[2]; x0 = cnt[3];
    host_rts(base);
    host_bits(base, {1'b1, 1'b0, 8'h00});
    wait_cnt(3, x0 + 1, 400, "t3 rx_err");
    repeat (3) step();
    check("t3 dat released", ps2_dat, 1);
    repeat (60) step();
    check("t3 fall count", falls - base, 10);
    check("t3 rx_ack pulses", cnt[2] - r0, 0);
    check("t3 rx_data held", rx_data, 8'hFF);
    check("t3 rx_err pulses", cnt[3] - x0, 1);
    repeat (100) step();

    // ---------------- 4: host inhibit during bit 4, then retry
    base = falls; a0 = cnt[0]; e0 = cnt[1];
    tx_data = 8'h3C; tx_en = 1'b1;
    wait_falls(base + 4, 1500, "t4 bit3");
    n = 0;
    while (ps2_clk !== 1'b1 && n < 100) begin step(); n++; end
    repeat (5) step();
    host_clk_low = 1'b1;
    t_pull = cyc;
    wait_cnt(1, e0 + 1, 100, "t4 tx_err");
    repeat (3) step();
    check("t4 dat released", ps2_dat, 1);
    check("t4 busy after err", tx_busy, 0);
    check("t4 no tx_ack", cnt[0] - a0, 0);
    while (cyc - t_pull < 100) step();
    host_clk_low = 1'b0;
    t_rel = cyc;
    base2 = falls;
    wait_cnt(0, a0 + 1, 2000, "t4 retry tx_ack");
    tx_en = 1'b0;
    check("t4 retry fall count", falls - base2, 11);
    check("t4 retry frame", frame_at(base2), 11'h678);
    check_range("t4 retry start delay", fall_cyc[base2 & 511] - t_rel, 70, 80);
    check("t4 tx_err pulses", cnt[1] - e0, 1);
    repeat (150) step();

    // ---------------- 5: tx_en and RTS in the same cycle
    a0 = cnt[0]; r0 = cnt[2];
    base = falls;
    host_dat_low = 1'b1;
    repeat (2) step();
    tx_data = 8'h81; tx_en = 1'b1;
    repeat (2) step();
    check("t5 rx wins", {rx_busy, tx_busy}, 2'b10);
    host_bits(base, {1'b1, 1'b1, 8'h5A});
    wait_cnt(2, r0 + 1, 600, "t5 rx_ack");
    check("t5 rx_data", rx_data, 8'h5A);
    check("t5 no tx yet", cnt[0] - a0, 0);
    base2 = base + 11;
    wait_cnt(0, a0 + 1, 2000, "t5 tx_ack");
    tx_en = 1'b0;
    check("t5 tx fall count", falls - base2, 11);
    check("t5 tx frame", frame_at(base2), 11'h702);
    check_range("t5 tx start delay", fall_cyc[base2 & 511] - rx_ack_cyc, 105, 118);
    repeat (150) step();

    // ---------------- 6: asynchronous reset mid-transmit at bit 6
    base = falls; a0 = cnt[0]; e0 = cnt[1];
    tx_data = 8'h00; tx_en = 1'b1;
    wait_falls(base + 7, 1500, "t6 bit6");
    repeat (10) step();
    check("t6 lines driven", {ps2_clk, ps2_dat}, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    check("t6 lines released", {ps2_clk, ps2_dat}, 2'b11);
    check("t6 tx_busy", tx_busy, 0);
    check("t6 pulses", {tx_ack, tx_err}, 2'b00);
    tx_en = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (100) step();
    check("t6 no tx_ack", cnt[0] - a0, 0);
    check("t6 no tx_err", cnt[1] - e0, 0);
    check("t6 rx_data cleared", rx_data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
